sm_mem_arbiter: RTL and testbench

SM_MEM_ARBITER -- requirements
Module: sm_mem_arbiter

---
 rtl/sm_mem_arbiter.sv | 113 +++++++++++
 tb/tb_sm_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port memory.
// Round-robin on contention, with a bounded wait for the memory ack.
module sm_mem_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iReq,
    input  logic [31:0] iAddr,
    output logic [31:0] iRdata,
    output logic        iAck,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    input  logic [3:0]  dBe,
    output logic [31:0] dRdata,
    output logic        dAck,
    output logic        mReq,
    output logic        mWe,
    output logic [31:0] mAddr,
    output logic [31:0] mWdata,
    output logic [3:0]  mBe,
    input  logic [31:0] mRdata,
    input  logic        mAck,
    output logic        busErr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t     state;
    logic       lastD;
    logic [7:0] waitCnt;

    logic busyI;
    logic busyD;
    logic busy;
    logic cntHit;
    logic timedOut;

    assign busyI    = (state == BUSY_I);
    assign busyD    = (state == BUSY_D);
    assign busy     = busyI | busyD;
    assign cntHit   = (waitCnt == (TIMEOUT - 8'd1));
    assign timedOut = busy & cntHit & ~mAck;

    // Arbitration, transfer completion and timeout counting
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lastD   <= 1'b1;
            waitCnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    waitCnt <= 8'd0;
                    // On contention, the port that was not served last wins
                    if (iReq && (!dReq || lastD)) begin
                        state <= BUSY_I;
                        lastD <= 1'b0;
                    end else if (dReq) begin
                        state <= BUSY_D;
                        lastD <= 1'b1;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mAck || timedOut) begin
                        state   <= IDLE;
                        waitCnt <= 8'd0;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    waitCnt <= 8'd0;
                end
            endcase
        end
    end

    // Memory-side mux and requester-side completion, all from current state
    always_comb begin
        mReq   = busy;
        mWe    = 1'b0;
        mAddr  = 32'd0;
        mWdata = 32'd0;
        mBe    = 4'd0;
        iAck   = 1'b0;
        iRdata = 32'd0;
        dAck   = 1'b0;
        dRdata = 32'd0;
        busErr = timedOut;
        if (busyI) begin
            mAddr  = iAddr;
            mBe    = 4'hF;
            iAck   = mAck | cntHit;
            iRdata = mAck ? mRdata : 32'd0;
        end else if (busyD) begin
            mWe    = dWe;
            mAddr  = dAddr;
            mWdata = dWdata;
            mBe    = dBe;
            dAck   = mAck | cntHit;
            dRdata = mAck ? mRdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// Directed self-checking bench for sm_mem_arbiter (TIMEOUT = 4).
module tb_sm_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        iReq;
    logic [31:0] iAddr;
    logic [31:0] iRdata;
    logic        iAck;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dBe;
    logic [31:0] dRdata;
    logic        dAck;
    logic        mReq;
    logic        mWe;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    logic [3:0]  mBe;
    logic [31:0] mRdata;
    logic        mAck;
    logic        busErr;

    int checks   = 0;
    int failures = 0;

    logic [136:0] allOut;
    assign allOut = {mReq, mWe, mAddr, mWdata, mBe, iAck, iRdata, dAck, dRdata, busErr};

    sm_mem_arbiter #(.TIMEOUT(8'd4)) dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iRdata(iRdata), .iAck(iAck),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dBe(dBe),
        .dRdata(dRdata), .dAck(dAck),
        .mReq(mReq), .mWe(mWe), .mAddr(mAddr), .mWdata(mWdata), .mBe(mBe),
        .mRdata(mRdata), .mAck(mAck), .busErr(busErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; callers then drive and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        iReq = 0; iAddr = 0; dReq = 0; dWe = 0; dAddr = 0;
        dWdata = 0; dBe = 0; mRdata = 0; mAck = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        iReq = 1; dReq = 1; iAddr = 32'h44; dAddr = 32'h88; #1;
        checks++;
        if (allOut !== 137'd0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0", allOut);
        end
        step(); #1;
        checks++;
        if (allOut !== 137'd0) begin
            failures++; $display("FAIL reset_held_outputs got=%h want=0", allOut);
        end
        clearInputs();
        rst = 0;
        step(); #1;
        checks++;
        if (allOut !== 137'd0) begin
            failures++; $display("FAIL post_reset_idle got=%h want=0", allOut);
        end
    endtask

    task automatic test_single_fetch();
        step();
        iReq = 1; iAddr = 32'h10; #1;
        checks++;
        if (mReq !== 1'b0) begin
            failures++; $display("FAIL fetch_c1_mreq got=%b want=0", mReq);
        end
        step(); #1;
        checks++;
        if ({mReq, mWe, mAddr, mBe, iAck, dAck} !== {1'b1, 1'b0, 32'h10, 4'hF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL fetch_c2 got mReq=%b mWe=%b mAddr=%h mBe=%h iAck=%b want 1 0 00000010 f 0",
                     mReq, mWe, mAddr, mBe, iAck);
        end
        step();
        mAck = 1; mRdata = 32'h24020005; #1;
        checks++;
        if ({mReq, iAck, iRdata, dAck, dRdata, busErr} !== {1'b1, 1'b1, 32'h24020005, 1'b0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL fetch_c3 got mReq=%b iAck=%b iRdata=%h dAck=%b busErr=%b want 1 1 24020005 0 0",
                     mReq, iAck, iRdata, dAck, busErr);
        end
        step();
        clearInputs(); #1;
        checks++;
        if (allOut !== 137'd0) begin
            failures++; $display("FAIL fetch_c4_idle got=%h want=0", allOut);
        end
    endtask

    task automatic test_data_write();
        step();
        dReq = 1; dWe = 1; dAddr = 32'h40; dWdata = 32'hCAFEF00D; dBe = 4'b0011; #1;
        for (int c = 0; c < 2; c++) begin
            step(); #1;
            checks++;
            if ({mReq, mWe, mAddr, mWdata, mBe, dAck, iAck} !==
                {1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'b0011, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL write_busy%0d got mReq=%b mWe=%b mAddr=%h mWdata=%h mBe=%b dAck=%b want 1 1 00000040 cafef00d 0011 0",
                         c, mReq, mWe, mAddr, mWdata, mBe, dAck);
            end
        end
        step();
        mAck = 1; mRdata = 32'h11111111; #1;
        checks++;
        if ({mWe, mBe, dAck, dRdata, iAck, busErr} !== {1'b1, 4'b0011, 1'b1, 32'h11111111, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL write_ack got mWe=%b mBe=%b dAck=%b dRdata=%h iAck=%b busErr=%b want 1 0011 1 11111111 0 0",
                     mWe, mBe, dAck, dRdata, iAck, busErr);
        end
        step();
        clearInputs(); #1;
        checks++;
        if (allOut !== 137'd0) begin
            failures++; $display("FAIL write_idle got=%h want=0", allOut);
        end
    endtask

    // Both ports held; memory acks one cycle after each mReq rise: I, D, I, D
    task automatic test_back_to_back();
        logic        even;
        logic        busy;
        logic        ackC;
        logic [31:0] rd;
        logic [71:0] got;
        logic [71:0] want;
        step();
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            iReq = 1; iAddr = 32'h100;
            dReq = 1; dAddr = 32'h200; dWe = 0; dWdata = 32'h0; dBe = 4'b1000;
            rd = 32'hA0000000 + 32'(i);
            mAck = (i % 3 == 2); mRdata = rd; #1;
            even = ((i / 3) % 2) == 0;
            busy = (i % 3) != 0;
            ackC = (i % 3) == 2;
            want = {busy,
                    busy ? (even ? 32'h100 : 32'h200) : 32'h0,
                    busy ? (even ? 4'hF : 4'b1000) : 4'h0,
                    ackC & even, ackC & ~even,
                    ackC ? rd : 32'h0, 1'b0};
            got  = {mReq, mAddr, mBe, iAck, dAck, iAck ? iRdata : dRdata, busErr};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL contention_cycle%0d got=%h want=%h", i + 1, got, want);
            end
        end
        step();
        clearInputs(); #1;
        checks++;
        if (allOut !== 137'd0) begin
            failures++; $display("FAIL contention_idle got=%h want=0", allOut);
        end
    endtask

    task automatic test_timeout();
        int reqCycles;
        reqCycles = 0;
        step();
        dReq = 1; dWe = 0; dAddr = 32'h80; mRdata = 32'hFFFF0000; #1;
        for (int c = 1; c <= 4; c++) begin
            step(); #1;
            if (mReq) reqCycles++;
            checks++;
            if ({dAck, busErr, dRdata} !== {(c == 4), (c == 4), 32'h0}) begin
                failures++;
                $display("FAIL timeout_busy%0d got dAck=%b busErr=%b dRdata=%h want %b %b 0",
                         c, dAck, busErr, dRdata, c == 4, c == 4);
            end
        end
        step();
        dReq = 0; #1;
        if (mReq) reqCycles++;
        checks++;
        if (reqCycles !== 4) begin
            failures++; $display("FAIL timeout_mreq_len got=%0d want=4", reqCycles);
        end
        step();
        dReq = 1; dAddr = 32'h84; #1;
        for (int c = 1; c <= 4; c++) begin
            step();
            mAck = (c == 4); mRdata = 32'h5A5A5A5A; #1;
        end
        checks++;
        if ({mReq, dAck, busErr, dRdata} !== {1'b1, 1'b1, 1'b0, 32'h5A5A5A5A}) begin
            failures++;
            $display("FAIL timeout_late_ack got mReq=%b dAck=%b busErr=%b dRdata=%h want 1 1 0 5a5a5a5a",
                     mReq, dAck, busErr, dRdata);
        end
        step();
        clearInputs(); #1;
        checks++;
        if (allOut !== 137'd0) begin
            failures++; $display("FAIL timeout_idle got=%h want=0", allOut);
        end
    endtask

    task automatic test_reset_mid();
        step();
        iReq = 1; iAddr = 32'h20; #1;
        step(); #1;
        step();
        rst = 1; #1;
        checks++;
        if ({mReq, iAck, busErr} !== 3'b100) begin
            failures++; $display("FAIL rstmid_busy got mReq=%b iAck=%b busErr=%b want 1 0 0", mReq, iAck, busErr);
        end
        step();
        rst = 0; iReq = 0; mAck = 1; mRdata = 32'h77777777; #1;
        checks++;
        if (allOut !== 137'd0) begin
            failures++; $display("FAIL rstmid_late_ack got=%h want=0", allOut);
        end
        step();
        clearInputs(); #1;
        checks++;
        if (allOut !== 137'd0) begin
            failures++; $display("FAIL rstmid_after got=%h want=0", allOut);
        end
    endtask

    task automatic test_stray_ack();
        for (int c = 0; c < 3; c++) begin
            step();
            mAck = (c < 2); mRdata = 32'hDEADBEEF; #1;
            checks++;
            if (allOut !== 137'd0) begin
                failures++; $display("FAIL stray_ack%0d got=%h want=0", c, allOut);
            end
        end
        clearInputs();
    endtask

    initial begin
        clearInputs();
        rst = 1;
        test_reset();
        test_single_fetch();
        test_data_write();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_stray_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
